// File: rtl/fir_sample_sequencer_if.sv
// -----------------------------------------------------------------------------
// fir_sample_sequencer_if
//
// Purpose:
//   Generic valid/ready stream bundle. The sequencer uses one instance
//   on its input side (samples arriving from the producer) and one on
//   its output side (filter results leaving towards the consumer).
//
// Signals:
//   valid  - data on 'data' is valid this cycle
//   ready  - receiver can accept a beat this cycle
//   data   - N-bit payload
//
// Modports:
//   master - drives valid/data, observes ready (the sending side)
//   slave  - observes valid/data, drives ready (the receiving side)
// -----------------------------------------------------------------------------
interface fir_sample_sequencer_if #(
    parameter int N = 16
);
    logic         valid;
    logic         ready;
    logic [N-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/fir_sample_sequencer.sv
// -----------------------------------------------------------------------------
// fir_sample_sequencer
//
// Purpose:
//   Feeds a time-multiplexed FIR filter from the producer side and reads
//   its result back. Incoming samples are buffered in a small FIFO; once
//   per programmable sample period the head sample is presented on fir_x_o
//   together with a one-cycle fir_en_o strobe. FILT_LAT cycles after the
//   strobe the filter output is captured and offered downstream over a
//   valid/ready stream. Sticky flags record underruns (period tick with an
//   empty FIFO) and overruns (new result while the previous one is still
//   unaccepted).
//
// Parameters:
//   N           sample/result width in bits
//   DEPTH       input FIFO depth in entries (power of 2, >= 2)
//   FILT_LAT    cycles from fir_en high to the captured result (>= 2)
//   MIN_PERIOD  minimum sample period in cycles (must exceed FILT_LAT)
//
// Ports:
//   clk           clock
//   rst           synchronous reset, active-high
//   run_i         1 = issue one sample per period, 0 = stop issuing
//   cfg_period_i  sample period in cycles, clamped up to MIN_PERIOD
//   clr_flags_i   clears the sticky underrun/overrun flags
//   s_if          slave stream: upstream samples (ready = FIFO not full)
//   fir_en_o      one-cycle strobe to the filter
//   fir_x_o       sample to the filter, held between strobes
//   fir_y_i       filter result
//   m_if          master stream: captured filter results
//   fifo_level_o  FIFO occupancy
//   underrun_o    sticky: period tick found the FIFO empty
//   overrun_o     sticky: result captured while the previous one was pending
//   drop_cnt_o    (only with FIR_SEQ_DROP_CNT_EN) saturating count of
//                 overrun events plus underrun ticks
//
// Build option:
//   FIR_SEQ_DROP_CNT_EN - when defined, adds drop_cnt_o and its counter.
// -----------------------------------------------------------------------------
module fir_sample_sequencer #(
    parameter int N          = 16,
    parameter int DEPTH      = 4,
    parameter int FILT_LAT   = 7,
    parameter int MIN_PERIOD = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run_i,
    input  logic [15:0]               cfg_period_i,
    input  logic                      clr_flags_i,
    fir_sample_sequencer_if.slave     s_if,
    output logic                      fir_en_o,
    output logic [N-1:0]              fir_x_o,
    input  logic [N-1:0]              fir_y_i,
    fir_sample_sequencer_if.master    m_if,
    output logic [$clog2(DEPTH):0]    fifo_level_o,
    output logic                      underrun_o,
    output logic                      overrun_o
`ifdef FIR_SEQ_DROP_CNT_EN
    ,
    output logic [15:0]               drop_cnt_o
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int LAT_W = $clog2(FILT_LAT + 1);
    localparam logic [15:0] MIN_P = 16'(MIN_PERIOD);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       period_q, period_d;
    logic [15:0]       cfg_clamped;
    logic              tick;

    logic [N-1:0]      mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic              fir_en_q, fir_en_d;
    logic [N-1:0]      fir_x_q, fir_x_d;

    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              capture;

    logic              m_valid_q, m_valid_d;
    logic [N-1:0]      m_data_q, m_data_d;

    logic              underrun_q, underrun_d;
    logic              overrun_q, overrun_d;
    logic              under_set;
    logic              over_set;

    // -------------------------------------------------------------------------
    // Period handling and handshake decodes
    // -------------------------------------------------------------------------
    assign cfg_clamped = (cfg_period_i < MIN_P) ? MIN_P : cfg_period_i;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // A full FIFO refuses the push even if a pop frees a slot this cycle,
    // so s_ready depends only on registered state.
    assign push  = s_if.valid && !full;
    assign pop   = tick && !empty;

    // The latency counter is loaded while fir_en is high and counts down;
    // reaching 1 marks the cycle whose fir_y is taken as the result.
    assign capture = (lat_q == LAT_W'(1));

    assign under_set = tick && empty;
    assign over_set  = capture && m_valid_q && !m_if.ready;

    // -------------------------------------------------------------------------
    // Sequencer FSM: next state, period counter and tick generation.
    // The period is latched on entry to RUN and again at every wrap, so a
    // change on cfg_period_i never shortens or stretches a period in flight.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        tick     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (run_i) begin
                    state_d  = RUN;
                    period_d = cfg_clamped;
                end
            end
            RUN: begin
                if (!run_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == period_q - 16'd1) begin
                    tick     = 1'b1;
                    cnt_d    = '0;
                    period_d = cfg_clamped;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO pointer and occupancy bookkeeping
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: reset empties the FIFO through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_if.data;
        end
    end

    // -------------------------------------------------------------------------
    // Filter drive, result capture, output stream and sticky flags.
    // fir_x is loaded together with fir_en so it is stable for the whole
    // strobe cycle and held until the next pop.
    // -------------------------------------------------------------------------
    always_comb begin
        fir_en_d   = pop;
        fir_x_d    = pop ? mem_q[rd_ptr_q] : fir_x_q;

        lat_d      = lat_q;
        if (fir_en_q) begin
            lat_d = LAT_W'(FILT_LAT - 1);
        end else if (lat_q != '0) begin
            lat_d = lat_q - LAT_W'(1);
        end

        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        if (capture) begin
            m_valid_d = 1'b1;
            m_data_d  = fir_y_i;
        end else if (m_valid_q && m_if.ready) begin
            m_valid_d = 1'b0;
        end

        // A set event in the same cycle as clr_flags wins.
        underrun_d = under_set ? 1'b1 : (clr_flags_i ? 1'b0 : underrun_q);
        overrun_d  = over_set  ? 1'b1 : (clr_flags_i ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fir_en_q   <= 1'b0;
            fir_x_q    <= '0;
            lat_q      <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            fir_en_q   <= fir_en_d;
            fir_x_q    <= fir_x_d;
            lat_q      <= lat_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef FIR_SEQ_DROP_CNT_EN
    // -------------------------------------------------------------------------
    // Drop counter: overrun events plus underrun ticks, saturating. Both
    // events can land in one cycle, so up to two are added at once.
    // -------------------------------------------------------------------------
    logic [15:0] drop_q, drop_d;
    logic [16:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, (clr_flags_i ? 16'h0000 : drop_q)}
                 + 17'(under_set) + 17'(over_set);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt_o = drop_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign s_if.ready   = !full;
    assign fir_en_o     = fir_en_q;
    assign fir_x_o      = fir_x_q;
    assign m_if.valid   = m_valid_q;
    assign m_if.data    = m_data_q;
    assign fifo_level_o = level_q;
    assign underrun_o   = underrun_q;
    assign overrun_o    = overrun_q;

endmodule
